sezer_onur_121044074: RTL and testbench

SEZER_ONUR_121044074 -- requirements
Module: sezer_onur_121044074

---
 rtl/sezer_onur_121044074.sv | 212 +++++++++++++++++++++
 tb/tb_sezer_onur_121044074.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sezer_onur_121044074.sv
// Single-cycle MIPS-32 subset processor: fetch, decode, execute, memory access
// and writeback all complete within one clock cycle.

module sezer_onur_121044074_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] arr [0:31];

  // $0 is hardwired: never written, always reads zero
  always_ff @(posedge clk) begin
    if (!reset && we && waddr != 5'd0) arr[waddr] <= wdata;
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : arr[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : arr[raddr_b];
endmodule

module sezer_onur_121044074_dmem #(
  parameter int unsigned DMEM_WORDS = 256,
  localparam int unsigned AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] dataArr [0:DMEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (!reset && we) dataArr[index] <= wdata;
  end

  assign rdata = dataArr[index];
endmodule

module sezer_onur_121044074_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  output logic [31:0] pc
);
  logic [31:0] pc_in;

  always_ff @(posedge clk) begin
    if (reset) pc_in <= 32'h0;
    else       pc_in <= pc_next;
  end

  assign pc = pc_in;
endmodule

module sezer_onur_121044074 #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] result
);
  localparam int unsigned IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA  = 6'h03, FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR  = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;

  logic [31:0] insArr [0:IMEM_WORDS-1];

  logic [31:0] pc, pc_plus4, pc_next, ins;
  logic [29:0] pc_word, mem_word;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, waddr;
  logic [15:0] imm;
  logic [31:0] sext, zext, a, b, alu, wdata, mem_rdata;
  logic        reg_we, mem_we;
  wb_sel_e     wb_sel;
  logic        unused_bits;

  // Out-of-range fetches return an all-zero word, which decodes as a nop
  assign pc_word  = pc[31:2];
  assign ins      = (pc_word < 30'(IMEM_WORDS)) ? insArr[IAW'(pc_word)] : 32'h0;
  assign pc_plus4 = pc + 32'd4;

  assign opcode = ins[31:26];
  assign rs     = ins[25:21];
  assign rt     = ins[20:16];
  assign rd     = ins[15:11];
  assign shamt  = ins[10:6];
  assign funct  = ins[5:0];
  assign imm    = ins[15:0];
  assign sext   = {{16{imm[15]}}, imm};
  assign zext   = {16'h0, imm};

  // Decode, execute and next-PC selection
  always_comb begin
    alu     = 32'h0;
    reg_we  = 1'b0;
    waddr   = rt;
    mem_we  = 1'b0;
    wb_sel  = WB_ALU;
    pc_next = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        waddr  = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu = a + b;
          FN_SUB, FN_SUBU: alu = a - b;
          FN_AND:  alu = a & b;
          FN_OR:   alu = a | b;
          FN_XOR:  alu = a ^ b;
          FN_NOR:  alu = ~(a | b);
          FN_SLT:  alu = {31'h0, $signed(a) < $signed(b)};
          FN_SLTU: alu = {31'h0, a < b};
          FN_SLL:  alu = b << shamt;
          FN_SRL:  alu = b >> shamt;
          FN_SRA:  alu = 32'($signed(b) >>> shamt);
          FN_JR: begin
            reg_we  = 1'b0;
            pc_next = a;
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu = a + sext; reg_we = 1'b1; end
      OP_SLTI: begin alu = {31'h0, $signed(a) < $signed(sext)}; reg_we = 1'b1; end
      OP_ANDI: begin alu = a & zext; reg_we = 1'b1; end
      OP_ORI:  begin alu = a | zext; reg_we = 1'b1; end
      OP_XORI: begin alu = a ^ zext; reg_we = 1'b1; end
      OP_LUI:  begin alu = {imm, 16'h0}; reg_we = 1'b1; end
      OP_LW: begin
        alu    = a + sext;
        reg_we = 1'b1;
        wb_sel = WB_MEM;
      end
      OP_SW: begin
        alu    = a + sext;
        mem_we = 1'b1;
      end
      OP_BEQ: begin
        alu = a - b;
        if (a == b) pc_next = pc_plus4 + {sext[29:0], 2'b00};
      end
      OP_BNE: begin
        alu = a - b;
        if (a != b) pc_next = pc_plus4 + {sext[29:0], 2'b00};
      end
      OP_J: pc_next = {pc_plus4[31:28], ins[25:0], 2'b00};
      OP_JAL: begin
        pc_next = {pc_plus4[31:28], ins[25:0], 2'b00};
        reg_we  = 1'b1;
        waddr   = 5'd31;
        wb_sel  = WB_LINK;
      end
      default: ;
    endcase
  end

  assign mem_word = alu[31:2] % 30'(DMEM_WORDS);
  assign wdata    = (wb_sel == WB_MEM)  ? mem_rdata :
                    (wb_sel == WB_LINK) ? pc_plus4  : alu;
  assign result   = alu;

  assign unused_bits = &{1'b0, pc[1:0], alu[1:0]};

  sezer_onur_121044074_pc pcModule (
    .clk     (clk),
    .reset   (reset),
    .pc_next (pc_next),
    .pc      (pc)
  );

  sezer_onur_121044074_regfile rMemory (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (a),
    .rdata_b (b)
  );

  sezer_onur_121044074_dmem #(.DMEM_WORDS(DMEM_WORDS)) dMemory (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .index (DAW'(mem_word)),
    .wdata (b),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_sezer_onur_121044074.sv
// Bench for sezer_onur_121044074: an instruction-level model runs in lockstep
// with the core, plus literal expectations for the key programs.

module tb_sezer_onur_121044074;
  localparam int IMEM = 64;
  localparam int DMEM = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] result;

  sezer_onur_121044074 #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM)) dut (
    .clk    (clk),
    .reset  (reset),
    .result (result)
  );

  always #5 clk = ~clk;

  logic [31:0] mi [0:IMEM-1];
  logic [31:0] mr [0:31];
  logic [31:0] md [0:DMEM-1];
  logic [31:0] mpc;
  logic [31:0] last_result;
  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_ins(int op, int t);
    return {6'(op), 26'(t)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic load_ins(input int idx, input logic [31:0] v);
    mi[idx] = v;
    dut.insArr[idx] = v;
  endtask
  task automatic set_reg(input int idx, input logic [31:0] v);
    mr[idx] = v;
    dut.rMemory.arr[idx] = v;
  endtask
  task automatic set_mem(input int idx, input logic [31:0] v);
    md[idx] = v;
    dut.dMemory.dataArr[idx] = v;
  endtask

  // Architectural model: executes the instruction at mpc
  task automatic model_cycle(input logic rst, output logic [31:0] res);
    logic [31:0] ins, a, b, se, ze, p4, npc, wv, ea;
    int op, fn, rs, rt, rd, sh, wr;
    logic do_sw;
    ins = ((mpc >> 2) < IMEM) ? mi[mpc >> 2] : 32'h0;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    rd = int'(ins[15:11]); sh = int'(ins[10:6]); fn = int'(ins[5:0]);
    a = (rs == 0) ? 32'h0 : mr[rs];
    b = (rt == 0) ? 32'h0 : mr[rt];
    se = 32'($signed(ins[15:0]));
    ze = 32'(ins[15:0]);
    ea = a + se;
    p4 = mpc + 32'd4;
    npc = p4; res = 32'h0; wr = -1; do_sw = 1'b0;
    case (op)
      0: begin
        wr = rd;
        case (fn)
          'h20, 'h21: res = a + b;
          'h22, 'h23: res = a - b;
          'h24: res = a & b;
          'h25: res = a | b;
          'h26: res = a ^ b;
          'h27: res = ~(a | b);
          'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          'h2B: res = (a < b) ? 32'd1 : 32'd0;
          'h00: res = b << sh;
          'h02: res = b >> sh;
          'h03: res = 32'($signed(b) >>> sh);
          'h08: begin npc = a; wr = -1; end
          default: wr = -1;
        endcase
      end
      'h08, 'h09: begin res = a + se; wr = rt; end
      'h0A: begin res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; wr = rt; end
      'h0C: begin res = a & ze; wr = rt; end
      'h0D: begin res = a | ze; wr = rt; end
      'h0E: begin res = a ^ ze; wr = rt; end
      'h0F: begin res = {ins[15:0], 16'h0}; wr = rt; end
      'h23: begin res = ea; wr = rt; end
      'h2B: begin res = ea; do_sw = 1'b1; end
      'h04: begin res = a - b; if (a == b) npc = p4 + (se << 2); end
      'h05: begin res = a - b; if (a != b) npc = p4 + (se << 2); end
      'h02: npc = {p4[31:28], ins[25:0], 2'b00};
      'h03: begin npc = {p4[31:28], ins[25:0], 2'b00}; wr = 31; end
      default: ;
    endcase
    if (op == 'h23)      wv = md[(ea >> 2) % DMEM];
    else if (op == 'h03) wv = p4;
    else                 wv = res;
    if (!rst) begin
      if (wr > 0) mr[wr] = wv;
      if (do_sw) md[(ea >> 2) % DMEM] = b;
    end
    mpc = rst ? 32'h0 : npc;
  endtask

  // One clock of lockstep comparison against the model
  task automatic cycle(input logic rst);
    logic [31:0] er;
    int bad_r, bad_m;
    reset = rst;
    @(negedge clk);
    check("pc", dut.pcModule.pc_in, mpc);
    model_cycle(rst, er);
    last_result = result;
    check("result", result, er);
    @(posedge clk);
    #1;
    bad_r = -1;
    for (int i = 0; i < 32; i++)
      if (bad_r < 0 && dut.rMemory.arr[i] !== mr[i]) bad_r = i;
    n_total++;
    if (bad_r < 0) n_pass++;
    else $display("FAIL regfile[%0d]: got %h expected %h", bad_r, dut.rMemory.arr[bad_r], mr[bad_r]);
    bad_m = -1;
    for (int i = 0; i < DMEM; i++)
      if (bad_m < 0 && dut.dMemory.dataArr[i] !== md[i]) bad_m = i;
    n_total++;
    if (bad_m < 0) n_pass++;
    else $display("FAIL dmem[%0d]: got %h expected %h", bad_m, dut.dMemory.dataArr[bad_m], md[bad_m]);
  endtask

  initial begin
    for (int i = 0; i < IMEM; i++) load_ins(i, 32'h0);
    for (int i = 0; i < 32; i++)   set_reg(i, 32'h0);
    for (int i = 0; i < DMEM; i++) set_mem(i, 32'h0);
    set_reg(1, 32'd5);
    set_reg(2, 32'd7);
    set_mem(3, 32'hDEADBEEF);

    load_ins(0,  r_ins(1, 2, 3, 0, 'h20));      // add  $3,$1,$2
    load_ins(1,  i_ins('h08, 0, 4, -1));        // addi $4,$0,-1
    load_ins(2,  r_ins(0, 4, 5, 0, 'h2B));      // sltu $5,$0,$4
    load_ins(3,  r_ins(0, 4, 6, 0, 'h2A));      // slt  $6,$0,$4
    load_ins(4,  i_ins('h08, 0, 1, 8));         // addi $1,$0,8
    load_ins(5,  i_ins('h23, 1, 7, 4));         // lw   $7,4($1)
    load_ins(6,  i_ins('h2B, 0, 7, 0));         // sw   $7,0($0)
    load_ins(7,  i_ins('h04, 0, 0, 2));         // beq  -> word 10
    load_ins(8,  i_ins('h08, 0, 8, 1));
    load_ins(9,  i_ins('h08, 0, 8, 1));
    load_ins(10, i_ins('h05, 0, 0, 2));         // bne not taken
    load_ins(11, j_ins('h03, 20));              // jal word 20
    load_ins(12, i_ins('h0F, 0, 10, 'h8000));   // lui  $10
    load_ins(13, r_ins(0, 10, 11, 4, 'h03));    // sra
    load_ins(14, r_ins(0, 10, 12, 4, 'h02));    // srl
    load_ins(15, r_ins(0, 4, 13, 3, 'h00));     // sll
    load_ins(16, r_ins(1, 2, 14, 0, 'h22));     // sub
    load_ins(17, r_ins(2, 1, 15, 0, 'h23));     // subu
    load_ins(18, j_ins('h02, 22));              // j word 22
    load_ins(19, i_ins('h08, 0, 8, 1));
    load_ins(20, r_ins(31, 0, 0, 0, 'h08));     // jr $31
    load_ins(21, i_ins('h08, 0, 8, 1));
    load_ins(22, i_ins('h0C, 4, 16, 'h8001));   // andi zero-extended
    load_ins(23, i_ins('h0D, 0, 17, 'hFFFF));   // ori
    load_ins(24, i_ins('h0E, 4, 18, 'h00FF));   // xori
    load_ins(25, r_ins(4, 7, 19, 0, 'h24));     // and
    load_ins(26, r_ins(1, 2, 20, 0, 'h25));     // or
    load_ins(27, r_ins(1, 2, 21, 0, 'h26));     // xor
    load_ins(28, r_ins(0, 0, 22, 0, 'h27));     // nor
    load_ins(29, i_ins('h0A, 4, 23, 0));        // slti
    load_ins(30, i_ins('h09, 4, 24, 2));        // addiu
    load_ins(31, i_ins('h08, 0, 0, 9));         // addi $0 ignored
    load_ins(32, i_ins('h3F, 0, 25, 1));        // undefined opcode
    load_ins(33, r_ins(1, 2, 26, 0, 'h3F));     // undefined funct
    load_ins(34, r_ins(4, 4, 27, 0, 'h20));     // add wraps
    load_ins(35, r_ins(4, 0, 28, 0, 'h2B));     // sltu
    load_ins(36, j_ins('h02, 36));              // spin

    @(posedge clk);
    #1;
    mpc = 32'h0;
    check("reset_pc", dut.pcModule.pc_in, 32'h0);

    cycle(1'b0);
    check("add_result_lit", last_result, 32'd12);
    for (int i = 0; i < 13; i++) cycle(1'b0);
    check("add_lit", dut.rMemory.arr[3], 32'd12);
    check("addi_lit", dut.rMemory.arr[4], 32'hFFFFFFFF);
    check("sltu_lit", dut.rMemory.arr[5], 32'd1);
    check("slt_lit", dut.rMemory.arr[6], 32'd0);
    check("lw_lit", dut.rMemory.arr[7], 32'hDEADBEEF);
    check("sw_lit", dut.dMemory.dataArr[0], 32'hDEADBEEF);
    check("jal_link_lit", dut.rMemory.arr[31], 32'd48);
    check("sra_lit", dut.rMemory.arr[11], 32'hF8000000);
    check("skipped_lit", dut.rMemory.arr[8], 32'd0);

    cycle(1'b1);
    check("midreset_pc_lit", dut.pcModule.pc_in, 32'h0);
    check("midreset_keep_lit", dut.rMemory.arr[3], 32'd12);

    for (int i = 0; i < 40; i++) cycle(1'b0);
    check("rerun_add_lit", dut.rMemory.arr[3], 32'd15);
    check("andi_lit", dut.rMemory.arr[16], 32'h00008001);
    check("xori_lit", dut.rMemory.arr[18], 32'hFFFFFF00);
    check("r0_lit", dut.rMemory.arr[0], 32'h0);
    check("slti_lit", dut.rMemory.arr[23], 32'd1);
    check("addiu_lit", dut.rMemory.arr[24], 32'd1);
    check("undef_op_lit", dut.rMemory.arr[25], 32'd0);
    check("undef_fn_lit", dut.rMemory.arr[26], 32'd0);
    check("wrap_lit", dut.rMemory.arr[27], 32'hFFFFFFFE);

    load_ins(0, i_ins('h04, 0, 0, 2));
    cycle(1'b1);
    cycle(1'b0);
    check("beq_pc_lit", dut.pcModule.pc_in, 32'd12);
    load_ins(0, i_ins('h05, 0, 0, 2));
    cycle(1'b1);
    cycle(1'b0);
    check("bne_pc_lit", dut.pcModule.pc_in, 32'd4);

    load_ins(0, j_ins('h02, 100));
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    check("oob_pc_lit", dut.pcModule.pc_in, 32'd404);
    check("oob_result_lit", last_result, 32'h0);

    for (int i = 0; i < 4; i++) load_ins(i, 32'h0);
    load_ins(4, j_ins('h03, 10));
    load_ins(10, r_ins(31, 0, 0, 0, 'h08));
    cycle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0);
    check("jal31_lit", dut.rMemory.arr[31], 32'h14);
    check("jal_pc_lit", dut.pcModule.pc_in, 32'h28);
    cycle(1'b0);
    check("jr_pc_lit", dut.pcModule.pc_in, 32'h14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
